// File: rtl/adc_sample_scheduler.sv
// -----------------------------------------------------------------------------
// adc_sample_scheduler
//
// Purpose:
//   Shares one serial ADC reader between two requesters: a free-running
//   periodic sample timer and a manual trigger (board switch). Each request
//   becomes one start/ack/done handshake with the reader. The result is
//   latched together with an unsigned "above threshold" flag for the LED and
//   comparator stage.
//
// Optional feature:
//   ADC_SCHED_TIMEOUT_EN - when defined, a watchdog aborts a conversion that
//   spends TIMEOUT cycles in START+WAIT and pulses timeout_err. When it is
//   undefined, the FSM waits for the reader indefinitely and timeout_err is
//   tied low.
//
// Parameters:
//   DATA_W   result width (ADC payload bits)
//   PERIOD   clk cycles between periodic requests (>= 8)
//   TIMEOUT  watchdog limit in cycles (used only with ADC_SCHED_TIMEOUT_EN)
//
// Ports:
//   clk          in   system clock, all logic on posedge
//   rst          in   asynchronous active-high reset
//   periodic_en  in   enables the periodic timer
//   manual_req   in   manual trigger level, a rising edge is one request
//   clr_ovr      in   clears the sticky overrun flag
//   rd_start     out  conversion request to the reader
//   rd_busy      in   reader busy (CS low), serves as the start acknowledge
//   rd_done      in   1-cycle pulse, rd_data valid
//   rd_data      in   reader result
//   threshold    in   comparator threshold
//   sample       out  last completed result
//   sample_valid out  1-cycle pulse when sample updates
//   above        out  sample > threshold (unsigned), held with sample
//   src_manual   out  1 when the last sample served a manual request
//   overrun      out  sticky, a periodic tick was lost
//   timeout_err  out  1-cycle pulse on watchdog abort
// -----------------------------------------------------------------------------
module adc_sample_scheduler #(
  parameter int DATA_W  = 8,
  parameter int PERIOD  = 1000,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              periodic_en,
  input  logic              manual_req,
  input  logic              clr_ovr,
  output logic              rd_start,
  input  logic              rd_busy,
  input  logic              rd_done,
  input  logic [DATA_W-1:0] rd_data,
  input  logic [DATA_W-1:0] threshold,
  output logic [DATA_W-1:0] sample,
  output logic              sample_valid,
  output logic              above,
  output logic              src_manual,
  output logic              overrun,
  output logic              timeout_err
);

  // Elaboration-time sanity checks on the configuration.
  if (PERIOD < 8) begin : g_bad_period
    $error("adc_sample_scheduler: PERIOD must be at least 8");
  end
  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("adc_sample_scheduler: TIMEOUT must be at least 2");
  end

  localparam int CNT_W = $clog2(PERIOD);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t              state_reg;
  logic [CNT_W-1:0]    cnt_reg;
  logic                manual_q_reg;
  logic                pend_m_reg;
  logic                pend_p_reg;
  logic                src_reg;
  logic                rd_start_reg;
  logic [DATA_W-1:0]   sample_reg;
  logic                sample_valid_reg;
  logic                above_reg;
  logic                src_manual_reg;
  logic                overrun_reg;

  logic                tick;
  logic                manual_rise;
  logic                take;
  logic                wd_expire;

  // ---------------------------------------------------------------------------
  // Request sources
  // ---------------------------------------------------------------------------
  assign tick        = periodic_en && (cnt_reg == CNT_W'(PERIOD - 1));
  assign manual_rise = manual_req && !manual_q_reg;

  // IDLE dispatches whatever is pending; this is the only place flags clear.
  assign take        = (state_reg == ST_IDLE) && (pend_m_reg || pend_p_reg);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (!periodic_en) begin
      cnt_reg <= '0;
    end else if (tick) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      manual_q_reg <= 1'b0;
      pend_m_reg   <= 1'b0;
      pend_p_reg   <= 1'b0;
      overrun_reg  <= 1'b0;
    end else begin
      manual_q_reg <= manual_req;
      // A new request arriving on the dispatch cycle must not be swallowed
      // by the clear, so the set term dominates.
      pend_m_reg   <= manual_rise || (pend_m_reg && !take);
      pend_p_reg   <= tick || (pend_p_reg && !take);
      // Set dominates clear so a loss coinciding with clr_ovr is not hidden.
      if (tick && pend_p_reg) begin
        overrun_reg <= 1'b1;
      end else if (clr_ovr) begin
        overrun_reg <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Watchdog (optional)
  // ---------------------------------------------------------------------------
`ifdef ADC_SCHED_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT);

  logic [WD_W-1:0] wd_reg;
  logic            timeout_err_reg;

  // wd_reg is 0 on the first START cycle, so expiry on TIMEOUT-1 aborts
  // exactly TIMEOUT cycles after START entry.
  assign wd_expire   = (wd_reg == WD_W'(TIMEOUT - 1));
  assign timeout_err = timeout_err_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_reg <= '0;
    end else if (state_reg == ST_IDLE) begin
      wd_reg <= '0;
    end else begin
      wd_reg <= wd_reg + 1'b1;
    end
  end
`else
  assign wd_expire   = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Conversion sequencer with registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg        <= ST_IDLE;
      src_reg          <= 1'b0;
      rd_start_reg     <= 1'b0;
      sample_reg       <= '0;
      sample_valid_reg <= 1'b0;
      above_reg        <= 1'b0;
      src_manual_reg   <= 1'b0;
`ifdef ADC_SCHED_TIMEOUT_EN
      timeout_err_reg  <= 1'b0;
`endif
    end else begin
      sample_valid_reg <= 1'b0;
`ifdef ADC_SCHED_TIMEOUT_EN
      timeout_err_reg  <= 1'b0;
`endif
      case (state_reg)
        ST_IDLE: begin
          if (take) begin
            state_reg    <= ST_START;
            rd_start_reg <= 1'b1;
            // Manual wins attribution when both requests are merged.
            src_reg      <= pend_m_reg;
          end
        end

        ST_START: begin
          if (wd_expire) begin
            state_reg       <= ST_IDLE;
            rd_start_reg    <= 1'b0;
`ifdef ADC_SCHED_TIMEOUT_EN
            timeout_err_reg <= 1'b1;
`endif
          end else if (rd_busy) begin
            state_reg    <= ST_WAIT;
            rd_start_reg <= 1'b0;
          end
        end

        ST_WAIT: begin
          // A completion on the expiry cycle is still a good result.
          if (rd_done) begin
            state_reg        <= ST_IDLE;
            sample_reg       <= rd_data;
            above_reg        <= (rd_data > threshold);
            src_manual_reg   <= src_reg;
            sample_valid_reg <= 1'b1;
          end else if (wd_expire) begin
            state_reg       <= ST_IDLE;
`ifdef ADC_SCHED_TIMEOUT_EN
            timeout_err_reg <= 1'b1;
`endif
          end
        end

        default: begin
          state_reg    <= ST_IDLE;
          rd_start_reg <= 1'b0;
        end
      endcase
    end
  end

  assign rd_start     = rd_start_reg;
  assign sample       = sample_reg;
  assign sample_valid = sample_valid_reg;
  assign above        = above_reg;
  assign src_manual   = src_manual_reg;
  assign overrun      = overrun_reg;

endmodule
